gas_alarm_controller: RTL and testbench
=======================================

GAS_ALARM_CONTROLLER -- requirements
Module: gas_alarm_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PERSIST, 4: consecutive qualifying samples needed to escalate.
- CLEAR_CYCLES, 16: consecutive qualifying samples needed to de-escalate.
- BEEP_HALF, 8: buzzer half-period in WARN, in cycles.
- WARN_LVL, 1: lowest level classed WARN.
- DANGER_LVL, 4: lowest level classed DANGER.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on the rising edge.
- arst, in, 1: reset; synchronous and active-high.
- level, in, 3: gas level from the upstream GasDetectorSensor dout, sampled every clk.
- ack, in, 1: operator acknowledge, level-sensitive, sampled every clk.
- state, out, 2: 0=SAFE, 1=WARN, 2=DANGER, 3=LATCHED.
- buzzer, out, 1: audible alarm drive.
- valve_close, out, 1: gas shut-off command.
- alarm_count, out, 8: number of entries into DANGER, saturating.

Function
REQ-003 Each cycle the block SHALL classify level as follows:
- DANGER if level>=DANGER_LVL.
- WARN if WARN_LVL<=level<DANGER_LVL.
- SAFE otherwise.
REQ-004 A single persistence counter pcnt SHALL increment on each cycle the current transition condition holds, clear on any cycle it fails, and clear on every state change.
REQ-005 From SAFE, the FSM SHALL go to WARN after PERSIST consecutive samples classed WARN or DANGER.
REQ-006 From WARN, the FSM SHALL go to DANGER after PERSIST consecutive DANGER samples, or to SAFE after CLEAR_CYCLES consecutive SAFE samples.
REQ-007 From DANGER, the FSM SHALL go to LATCHED after CLEAR_CYCLES consecutive samples classed below DANGER.
REQ-008 From LATCHED:
- go to DANGER after PERSIST consecutive DANGER samples;
- otherwise go to SAFE on a cycle with ack=1 and level classed SAFE;
- otherwise stay LATCHED.
REQ-009 level==7 SHALL force DANGER at the next edge from any state except DANGER, overriding all other conditions.
REQ-010 The transition SHALL take place on the edge at which the PERSIST-th (or CLEAR_CYCLES-th) qualifying sample is taken, so state changes PERSIST edges after the first qualifying sample.
REQ-011 If escalation and ack complete on the same cycle, escalation SHALL win.
REQ-012 buzzer SHALL behave per state:
- WARN: toggle every BEEP_HALF cycles, starting at 1 on WARN entry.
- DANGER: constant 1 unless muted.
- SAFE and LATCHED: 0.
REQ-013 ack=1 in DANGER SHALL set a mute flag that forces buzzer to 0; the mute flag SHALL clear whenever DANGER is exited.
REQ-014 valve_close SHALL be 1 in DANGER and LATCHED, and 0 otherwise.
REQ-015 alarm_count SHALL increment by 1 on each entry into DANGER and SHALL saturate at 255.
REQ-016 All outputs SHALL be registered; they reflect the new state in the cycle after the transition edge.
REQ-017 pcnt SHALL be wide enough for max(PERSIST, CLEAR_CYCLES) and SHALL NOT wrap.

Reset
REQ-018 arst=1 at a rising edge SHALL set the following, regardless of any operation in progress:
- state=SAFE;
- buzzer=0, valve_close=0, alarm_count=0;
- pcnt, the beep counter and the mute flag cleared.
REQ-019 A 1-cycle arst pulse SHALL fully reset the block, and inputs SHALL be ignored on reset cycles.

Structure
REQ-020 Package gas_alarm_pkg SHALL hold:
- the state encoding;
- the SAFE/WARN/DANGER class encoding;
- default threshold and timing constants.
REQ-021 One sub-module, gas_alarm_beeper, SHALL be used:
- inputs: enable and restart;
- output: the square wave of half-period BEEP_HALF.

Verification
REQ-022 Reset, then level=2 for 4 cycles -> state=WARN after the 4th edge; buzzer=1 for 8 cycles, then 0 for 8.
REQ-023 From WARN, level=5 for 3 cycles, then 2, then 5 for 4 cycles -> state=DANGER only after the final 4-cycle run; valve_close=1; alarm_count=1.
REQ-024 From SAFE, level=7 for 1 cycle -> state=DANGER at the next edge; buzzer=1; ack=1 -> buzzer=0 while state remains DANGER.
REQ-025 From DANGER, level=0 for 16 cycles -> state=LATCHED, valve_close=1, buzzer=0; then ack=1 with level=0 -> state=SAFE, valve_close=0.
REQ-026 In LATCHED, ack=1 on the same edge that completes 4 DANGER samples -> state=DANGER.
REQ-027 arst pulse for 1 cycle mid-DANGER with alarm_count=3 -> state=SAFE and all outputs 0 the next cycle.
REQ-028 300 DANGER entries -> alarm_count holds at 255.

Source files
------------

// File: rtl/gas_alarm_pkg.sv
// Shared encodings and default tuning constants for the gas alarm controller.
package gas_alarm_pkg;

  // Controller state as seen on the state output.
  typedef enum logic [1:0] {
    StSafe    = 2'd0,
    StWarn    = 2'd1,
    StDanger  = 2'd2,
    StLatched = 2'd3
  } state_e;

  // Per-sample classification of the sensor level.
  typedef enum logic [1:0] {
    ClsSafe   = 2'd0,
    ClsWarn   = 2'd1,
    ClsDanger = 2'd2
  } class_e;

  localparam int unsigned DefPersist     = 4;
  localparam int unsigned DefClearCycles = 16;
  localparam int unsigned DefBeepHalf    = 8;
  localparam int unsigned DefWarnLvl     = 1;
  localparam int unsigned DefDangerLvl   = 4;

  // Level at which the controller jumps straight to DANGER.
  localparam logic [2:0] ForceLvl = 3'd7;

  function automatic class_e classify(input logic [2:0] lvl, input int unsigned warn_lvl,
                                      input int unsigned danger_lvl);
    if (32'(lvl) >= danger_lvl) begin
      return ClsDanger;
    end else if (32'(lvl) >= warn_lvl) begin
      return ClsWarn;
    end
    return ClsSafe;
  endfunction

endpackage

// File: rtl/gas_alarm_beeper.sv
// Square-wave generator for the buzzer. Holding restart keeps the output at a
// steady 1, which the controller uses for the continuous DANGER tone.
module gas_alarm_beeper #(
  parameter int unsigned BEEP_HALF = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic restart_i,
  output logic wave_o
);

  localparam int unsigned HalfW = $clog2(BEEP_HALF + 1);

  logic             wave_q, wave_d;
  logic [HalfW-1:0] cnt_q, cnt_d;

  // Next phase: restart starts a high half-period, otherwise toggle every BEEP_HALF cycles.
  always_comb begin
    wave_d = wave_q;
    cnt_d  = cnt_q;
    if (restart_i) begin
      wave_d = 1'b1;
      cnt_d  = '0;
    end else if (enable_i) begin
      if (cnt_q == HalfW'(BEEP_HALF - 1)) begin
        wave_d = ~wave_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      wave_d = 1'b0;
      cnt_d  = '0;
    end
  end

  // Phase registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wave_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wave_q <= wave_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: debounces classified sensor levels into a four-state
// alarm FSM and drives buzzer, shut-off valve and a saturating alarm counter.
module gas_alarm_controller
  import gas_alarm_pkg::*;
#(
  parameter int unsigned PERSIST      = DefPersist,
  parameter int unsigned CLEAR_CYCLES = DefClearCycles,
  parameter int unsigned BEEP_HALF    = DefBeepHalf,
  parameter int unsigned WARN_LVL     = DefWarnLvl,
  parameter int unsigned DANGER_LVL   = DefDangerLvl
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [2:0] level,
  input  logic       ack,
  output logic [1:0] state,
  output logic       buzzer,
  output logic       valve_close,
  output logic [7:0] alarm_count
);

  localparam int unsigned MaxCnt = (PERSIST > CLEAR_CYCLES) ? PERSIST : CLEAR_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW:0] PersistTh = (CntW + 1)'(PERSIST);
  localparam logic [CntW:0] ClearTh   = (CntW + 1)'(CLEAR_CYCLES);

  state_e          state_q, state_d;
  logic [CntW-1:0] pcnt_q, pcnt_d;
  logic            run_danger_q, run_danger_d;  // which run pcnt is timing while in WARN
  logic            mute_q, mute_d;
  logic            valve_q, valve_d;
  logic [7:0]      count_q, count_d;

  class_e          cls;
  logic [CntW:0]   inc;
  logic [CntW:0]   run;
  logic            danger_tone;
  logic            beep_en;
  logic            beep_restart;

  assign cls = classify(level, WARN_LVL, DANGER_LVL);
  // One extra bit so the comparison against the threshold can never wrap.
  assign inc = {1'b0, pcnt_q} + 1'b1;

  // Next state and persistence counter.
  always_comb begin
    state_d      = state_q;
    pcnt_d       = '0;
    run_danger_d = run_danger_q;
    run          = '0;
    unique case (state_q)
      StSafe: begin
        if (cls != ClsSafe) begin
          if (inc >= PersistTh) state_d = StWarn;
          else                  pcnt_d  = inc[CntW-1:0];
        end
      end
      StWarn: begin
        if (cls == ClsDanger) begin
          run          = (pcnt_q != '0 && run_danger_q) ? inc : (CntW + 1)'(1);
          run_danger_d = 1'b1;
          if (run >= PersistTh) state_d = StDanger;
          else                  pcnt_d  = run[CntW-1:0];
        end else if (cls == ClsSafe) begin
          run          = (pcnt_q != '0 && !run_danger_q) ? inc : (CntW + 1)'(1);
          run_danger_d = 1'b0;
          if (run >= ClearTh) state_d = StSafe;
          else                pcnt_d  = run[CntW-1:0];
        end
      end
      StDanger: begin
        if (cls != ClsDanger) begin
          if (inc >= ClearTh) state_d = StLatched;
          else                pcnt_d  = inc[CntW-1:0];
        end
      end
      StLatched: begin
        // Escalation is checked first so it beats a simultaneous ack.
        if (cls == ClsDanger) begin
          if (inc >= PersistTh) state_d = StDanger;
          else                  pcnt_d  = inc[CntW-1:0];
        end else if (ack && cls == ClsSafe) begin
          state_d = StSafe;
        end
      end
      default: state_d = StSafe;
    endcase

    if (level == ForceLvl && state_q != StDanger) begin
      state_d = StDanger;
    end
    if (state_d != state_q) begin
      pcnt_d = '0;
    end
  end

  // Next values of the registered outputs, all derived from the next state.
  always_comb begin
    mute_d = 1'b0;
    if (state_d == StDanger) begin
      mute_d = mute_q | (ack && state_q == StDanger);
    end
    valve_d = (state_d == StDanger) || (state_d == StLatched);
    count_d = count_q;
    if (state_d == StDanger && state_q != StDanger && count_q != 8'hFF) begin
      count_d = count_q + 8'd1;
    end
    danger_tone  = (state_d == StDanger) && !mute_d;
    beep_en      = (state_d == StWarn) || danger_tone;
    beep_restart = ((state_d == StWarn) && (state_q != StWarn)) || danger_tone;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= StSafe;
      pcnt_q       <= '0;
      run_danger_q <= 1'b0;
      mute_q       <= 1'b0;
      valve_q      <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      run_danger_q <= run_danger_d;
      mute_q       <= mute_d;
      valve_q      <= valve_d;
      count_q      <= count_d;
    end
  end

  gas_alarm_beeper #(
    .BEEP_HALF(BEEP_HALF)
  ) u_beeper (
    .clk_i    (clk),
    .rst_i    (arst),
    .enable_i (beep_en),
    .restart_i(beep_restart),
    .wave_o   (buzzer)
  );

  assign state       = state_q;
  assign valve_close = valve_q;
  assign alarm_count = count_q;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Directed self-checking bench for gas_alarm_controller with default parameters.
module tb_gas_alarm_controller;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [2:0] level = 3'd0;
  logic       ack = 1'b0;
  logic [1:0] state;
  logic       buzzer;
  logic       valve_close;
  logic [7:0] alarm_count;

  int vectors = 0;
  int errors  = 0;

  gas_alarm_controller dut (
    .clk        (clk),
    .arst       (arst),
    .level      (level),
    .ack        (ack),
    .state      (state),
    .buzzer     (buzzer),
    .valve_close(valve_close),
    .alarm_count(alarm_count)
  );

  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [2:0] lvl, input logic a, input int n);
    for (int i = 0; i < n; i++) begin
      level = lvl;
      ack   = a;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with hostile inputs, which must be ignored.
    arst = 1'b1;
    step(3'd7, 1'b1, 2);
    check("rst_state", 32'(state), 0);
    check("rst_buzzer", 32'(buzzer), 0);
    check("rst_valve", 32'(valve_close), 0);
    check("rst_count", 32'(alarm_count), 0);
    arst = 1'b0;

    // SAFE -> WARN after 4 WARN samples; buzzer 8 high, 8 low.
    step(3'd2, 1'b0, 3);
    check("warn_3rd", 32'(state), 0);
    step(3'd2, 1'b0, 1);
    check("warn_entry", 32'(state), 1);
    check("warn_buz_on", 32'(buzzer), 1);
    check("warn_valve", 32'(valve_close), 0);
    step(3'd2, 1'b0, 7);
    check("warn_buz_8th", 32'(buzzer), 1);
    step(3'd2, 1'b0, 1);
    check("warn_buz_off", 32'(buzzer), 0);
    step(3'd2, 1'b0, 7);
    check("warn_buz_16th", 32'(buzzer), 0);
    step(3'd2, 1'b0, 1);
    check("warn_buz_again", 32'(buzzer), 1);
    check("warn_hold", 32'(state), 1);

    // Broken DANGER run restarts the persistence count.
    step(3'd5, 1'b0, 3);
    check("dng_run3", 32'(state), 1);
    step(3'd2, 1'b0, 1);
    step(3'd5, 1'b0, 3);
    check("dng_run3b", 32'(state), 1);
    step(3'd5, 1'b0, 1);
    check("dng_entry", 32'(state), 2);
    check("dng_valve", 32'(valve_close), 1);
    check("dng_count", 32'(alarm_count), 1);
    check("dng_buz", 32'(buzzer), 1);

    // Mute in DANGER.
    step(3'd5, 1'b1, 1);
    check("mute_buz", 32'(buzzer), 0);
    check("mute_state", 32'(state), 2);

    // DANGER -> LATCHED after 16 sub-DANGER samples, then ack to SAFE.
    step(3'd0, 1'b0, 15);
    check("latch_15", 32'(state), 2);
    step(3'd0, 1'b0, 1);
    check("latch_entry", 32'(state), 3);
    check("latch_valve", 32'(valve_close), 1);
    check("latch_buz", 32'(buzzer), 0);
    step(3'd0, 1'b1, 1);
    check("ack_safe", 32'(state), 0);
    check("ack_valve", 32'(valve_close), 0);

    // level 7 forces DANGER from SAFE; mute via ack.
    step(3'd7, 1'b0, 1);
    check("force_state", 32'(state), 2);
    check("force_buz", 32'(buzzer), 1);
    check("force_count", 32'(alarm_count), 2);
    step(3'd7, 1'b1, 1);
    check("force_mute", 32'(buzzer), 0);
    check("force_hold", 32'(state), 2);

    // LATCHED: ack at WARN level does not clear; escalation beats ack.
    step(3'd0, 1'b0, 16);
    check("latch2", 32'(state), 3);
    step(3'd2, 1'b1, 1);
    check("latch_ack_warn", 32'(state), 3);
    step(3'd5, 1'b0, 3);
    check("latch_dng3", 32'(state), 3);
    step(3'd5, 1'b1, 1);
    check("esc_wins", 32'(state), 2);
    check("esc_count", 32'(alarm_count), 3);
    check("esc_buz", 32'(buzzer), 1);

    // One-cycle reset mid-DANGER.
    arst = 1'b1;
    step(3'd7, 1'b1, 1);
    arst = 1'b0;
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_buz", 32'(buzzer), 0);
    check("mid_rst_valve", 32'(valve_close), 0);
    check("mid_rst_count", 32'(alarm_count), 0);
    step(3'd0, 1'b0, 1);
    check("post_rst", 32'(state), 0);

    // Saturation of the DANGER entry counter.
    step(3'd7, 1'b0, 1);
    check("sat_first", 32'(alarm_count), 1);
    for (int i = 0; i < 254; i++) begin
      step(3'd0, 1'b0, 16);
      step(3'd7, 1'b0, 1);
    end
    check("sat_255", 32'(alarm_count), 255);
    for (int i = 0; i < 45; i++) begin
      step(3'd0, 1'b0, 16);
      step(3'd7, 1'b0, 1);
    end
    check("sat_300", 32'(alarm_count), 255);
    check("sat_state", 32'(state), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
